// File: rtl/pad_in_conditioner_if.sv
// Pad-side bundle for pad_in_conditioner: raw pad inputs in, conditioned levels/pulses out.
// The master side drives the raw pads; the conditioner uses the slave side.
interface pad_in_conditioner_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic             uart_sin_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;
    logic             uart_sin_sync;

    modport master (
        output btn_raw, uart_sin_raw,
        input  btn_level, btn_press, btn_release, btn_long, uart_sin_sync
    );

    modport slave (
        input  btn_raw, uart_sin_raw,
        output btn_level, btn_press, btn_release, btn_long, uart_sin_sync
    );
endinterface

// File: rtl/pad_in_conditioner.sv
// Purpose: synchronise pad inputs; debounce buttons into level + press/release (+ long-press with BTN_LONG_PRESS_EN).
// Latency: SYNC_STAGES cycles for uart_sin_sync; button commits (DB_TICKS-1)*TICK_DIV+1..DB_TICKS*TICK_DIV after sync.
// Backpressure: none; pads are sampled every clk and pulses are single-cycle.
module pad_in_conditioner #(
    parameter int N_BTN       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 1000,
    parameter int DB_TICKS    = 250,
    parameter int CNT_W       = 16,
    parameter int LONG_TICKS  = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    pad_in_conditioner_if.slave pads
);

    typedef enum logic [1:0] {S0, C1, S1, C0} db_state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_TICKS - 1);

    if (SYNC_STAGES < 2 || TICK_DIV < 2 || DB_TICKS < 1 || LONG_TICKS < 1) begin : g_cfg_check
        $error("pad_in_conditioner: illegal parameter set");
    end

    logic [N_BTN-1:0]       btn_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] uart_sync;
    logic [N_BTN-1:0]       s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) btn_sync[k] <= '0;
            uart_sync <= '1;
        end else begin
            btn_sync[0] <= pads.btn_raw;
            for (int k = 1; k < SYNC_STAGES; k++) btn_sync[k] <= btn_sync[k-1];
            uart_sync <= {uart_sync[SYNC_STAGES-2:0], pads.uart_sin_raw};
        end
    end

    assign s                  = btn_sync[SYNC_STAGES-1];
    assign pads.uart_sin_sync = uart_sync[SYNC_STAGES-1];

    // Free-running sample tick, shared by every button and never restarted.
    logic [CNT_W-1:0] presc;
    logic             tick;

    assign tick = (presc == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    db_state_t        state     [N_BTN];
    db_state_t        state_nxt [N_BTN];
    logic [CNT_W-1:0] cnt       [N_BTN];
    logic [CNT_W-1:0] cnt_nxt   [N_BTN];
    logic [N_BTN-1:0] level_q, level_nxt;
    logic [N_BTN-1:0] press_q, press_nxt;
    logic [N_BTN-1:0] release_q, release_nxt;

    // Bounce aborts are checked every cycle and win over tick counting.
    always_comb begin
        level_nxt   = '0;
        press_nxt   = '0;
        release_nxt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                S0: if (s[i]) begin
                        state_nxt[i] = C1;
                        cnt_nxt[i]   = '0;
                    end
                C1: if (!s[i]) begin
                        state_nxt[i] = S0;
                        cnt_nxt[i]   = '0;
                    end else if (tick) begin
                        if (cnt[i] == DB_LAST) begin
                            state_nxt[i] = S1;
                            cnt_nxt[i]   = '0;
                            press_nxt[i] = 1'b1;
                        end else begin
                            cnt_nxt[i] = cnt[i] + 1'b1;
                        end
                    end
                S1: if (!s[i]) begin
                        state_nxt[i] = C0;
                        cnt_nxt[i]   = '0;
                    end
                C0: if (s[i]) begin
                        state_nxt[i] = S1;
                        cnt_nxt[i]   = '0;
                    end else if (tick) begin
                        if (cnt[i] == DB_LAST) begin
                            state_nxt[i]   = S0;
                            cnt_nxt[i]     = '0;
                            release_nxt[i] = 1'b1;
                        end else begin
                            cnt_nxt[i] = cnt[i] + 1'b1;
                        end
                    end
                default: begin
                    state_nxt[i] = S0;
                    cnt_nxt[i]   = '0;
                end
            endcase
            level_nxt[i] = (state_nxt[i] == S1) || (state_nxt[i] == C0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= S0;
                cnt[i]   <= '0;
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            level_q   <= level_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
        end
    end

    assign pads.btn_level   = level_q;
    assign pads.btn_press   = press_q;
    assign pads.btn_release = release_q;

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

    logic [CNT_W-1:0] hold     [N_BTN];
    logic [CNT_W-1:0] hold_nxt [N_BTN];
    logic [N_BTN-1:0] long_q, long_nxt;

    // Hold time spans C0 bounces; saturation at LONG_MAX gives one pulse per press.
    always_comb begin
        long_nxt = '0;
        for (int i = 0; i < N_BTN; i++) begin
            hold_nxt[i] = hold[i];
            if (state[i] == C1 && state_nxt[i] == S1) begin
                hold_nxt[i] = '0;
            end else if ((state[i] == S1 || state[i] == C0) && tick && hold[i] != LONG_MAX) begin
                hold_nxt[i] = hold[i] + 1'b1;
                long_nxt[i] = (hold[i] == LONG_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) hold[i] <= '0;
            long_q <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) hold[i] <= hold_nxt[i];
            long_q <= long_nxt;
        end
    end

    assign pads.btn_long = long_q;
`else
    assign pads.btn_long = '0;
`endif

endmodule

// File: tb/tb_pad_in_conditioner.sv
// Bench for pad_in_conditioner: directed scenarios plus random button/uart activity against a reference model.
module tb_pad_in_conditioner;

    localparam int N_BTN       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int TICK_DIV    = 4;
    localparam int DB_TICKS    = 3;
    localparam int CNT_W       = 16;
    localparam int LONG_TICKS  = 8;
`ifdef BTN_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    pad_in_conditioner_if #(.N_BTN(N_BTN)) pads ();

    pad_in_conditioner #(
        .N_BTN(N_BTN), .SYNC_STAGES(SYNC_STAGES), .TICK_DIV(TICK_DIV),
        .DB_TICKS(DB_TICKS), .CNT_W(CNT_W), .LONG_TICKS(LONG_TICKS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .pads (pads)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a button flips once its synced input has disagreed with
    // the accepted level for a run that covers DB_TICKS ticks after its first cycle.
    logic [N_BTN-1:0] q_b [$];
    logic             q_u [$];
    int               m_edge;
    logic [N_BTN-1:0] m_lvl, m_press, m_rel, m_long;
    logic             m_uart;
    int               m_run  [N_BTN];
    int               m_nt   [N_BTN];
    int               m_hold [N_BTN];

    int               press_cnt [N_BTN];
    int               rel_cnt   [N_BTN];
    int               long_cnt  [N_BTN];
    logic [N_BTN-1:0] first_press, first_rel;
    int               press_edge0;
    int               uart_low_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_b.delete();
        q_u.delete();
        for (int k = 0; k < SYNC_STAGES; k++) begin
            q_b.push_back('0);
            q_u.push_back(1'b1);
        end
        m_edge = 0;
        m_lvl  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            m_run[i]  = 0;
            m_nt[i]   = 0;
            m_hold[i] = 0;
        end
    endtask

    task automatic model_step(input logic [N_BTN-1:0] b, input logic u);
        logic [N_BTN-1:0] sv;
        logic             tk;
        sv = q_b.pop_front();
        q_b.push_back(b);
        void'(q_u.pop_front());
        q_u.push_back(u);
        m_uart  = q_u[0];
        tk      = ((m_edge % TICK_DIV) == TICK_DIV - 1);
        m_edge++;
        m_press = '0;
        m_rel   = '0;
        m_long  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (m_lvl[i] && tk && m_hold[i] < LONG_TICKS) begin
                m_hold[i]++;
                if (m_hold[i] == LONG_TICKS) m_long[i] = LONG_EN;
            end
            if (sv[i] != m_lvl[i]) begin
                if (m_run[i] > 0 && tk) m_nt[i]++;
                m_run[i]++;
                if (m_nt[i] == DB_TICKS) begin
                    m_lvl[i] = sv[i];
                    if (sv[i]) begin
                        m_press[i] = 1'b1;
                        m_hold[i]  = 0;
                    end else begin
                        m_rel[i] = 1'b1;
                    end
                    m_run[i] = 0;
                    m_nt[i]  = 0;
                end
            end else begin
                m_run[i] = 0;
                m_nt[i]  = 0;
            end
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N_BTN; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
            long_cnt[i]  = 0;
        end
        first_press  = '0;
        first_rel    = '0;
        press_edge0  = -1;
        uart_low_cnt = 0;
    endtask

    task automatic cyc(input logic [N_BTN-1:0] b, input logic u);
        pads.btn_raw      = b;
        pads.uart_sin_raw = u;
        @(posedge clk);
        model_step(b, u);
        #1;
        chk("level",   32'(pads.btn_level),     32'(m_lvl));
        chk("press",   32'(pads.btn_press),     32'(m_press));
        chk("release", 32'(pads.btn_release),   32'(m_rel));
        chk("long",    32'(pads.btn_long),      32'(m_long));
        chk("uart",    32'(pads.uart_sin_sync), 32'(m_uart));
        for (int i = 0; i < N_BTN; i++) begin
            press_cnt[i] += int'(pads.btn_press[i]);
            rel_cnt[i]   += int'(pads.btn_release[i]);
            long_cnt[i]  += int'(pads.btn_long[i]);
        end
        if (first_press == '0) first_press = pads.btn_press;
        if (first_rel == '0)   first_rel   = pads.btn_release;
        if (pads.btn_press[0] && press_edge0 < 0) press_edge0 = m_edge - 1;
        if (!pads.uart_sin_sync) uart_low_cnt++;
    endtask

    // Called at posedge+1; reset asserts immediately and is released at posedge+1.
    task automatic apply_reset(input logic [N_BTN-1:0] b, input logic u, input int n);
        rst_n             = 1'b0;
        pads.btn_raw      = b;
        pads.uart_sin_raw = u;
        #1;
        chk("rst_level",   32'(pads.btn_level),     32'h0);
        chk("rst_press",   32'(pads.btn_press),     32'h0);
        chk("rst_release", 32'(pads.btn_release),   32'h0);
        chk("rst_long",    32'(pads.btn_long),      32'h0);
        chk("rst_uart",    32'(pads.uart_sin_sync), 32'h1);
        repeat (n) @(posedge clk);
        #1;
        chk("rst_hold_level", 32'(pads.btn_level),     32'h0);
        chk("rst_hold_uart",  32'(pads.uart_sin_sync), 32'h1);
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N_BTN-1:0] rb;
        int               r_edge;
        int               lat;

        rst_n             = 1'b0;
        pads.btn_raw      = '1;
        pads.uart_sin_raw = 1'b0;
        clear_stats();
        @(posedge clk);
        #1;

        // Buttons held through reset release are accepted after debounce.
        apply_reset(4'hF, 1'b0, 3);
        clear_stats();
        repeat (14) cyc(4'hF, 1'b0);
        chk("held_reset_press", 32'(first_press), 32'hF);

        // Clean press on button 0.
        apply_reset(4'h0, 1'b1, 2);
        clear_stats();
        repeat (3) cyc(4'h0, 1'b1);
        cyc(4'h1, 1'b1);
        r_edge = m_edge - 1;
        repeat (20) cyc(4'h1, 1'b1);
        lat = press_edge0 - (r_edge + SYNC_STAGES);
        chk("press_latency",  32'(lat >= 9 && lat <= 12), 32'h1);
        chk("clean_press_n",  32'(press_cnt[0]), 32'd1);
        chk("clean_release_n", 32'(rel_cnt[0]), 32'd0);
        chk("clean_level",    32'(pads.btn_level[0]), 32'h1);

        // Bounce on button 1, then settle high.
        apply_reset(4'h0, 1'b1, 2);
        clear_stats();
        for (int seg = 0; seg < 8; seg++)
            repeat (5) cyc((seg % 2 == 0) ? 4'h2 : 4'h0, 1'b1);
        chk("bounce_quiet", 32'(press_cnt[1]), 32'd0);
        repeat (20) cyc(4'h2, 1'b1);
        chk("bounce_press_n", 32'(press_cnt[1]), 32'd1);

        // Simultaneous press and release on buttons 2 and 3.
        apply_reset(4'h0, 1'b1, 2);
        clear_stats();
        repeat (16) cyc(4'hC, 1'b1);
        chk("simul_press", 32'(first_press), 32'hC);
        repeat (16) cyc(4'h0, 1'b1);
        chk("simul_release", 32'(first_rel), 32'hC);
        chk("simul_press_n", 32'(press_cnt[2] + press_cnt[3]), 32'd2);

        // UART falling edge latency and glitch pass-through.
        repeat (3) cyc(4'h0, 1'b1);
        cyc(4'h0, 1'b0);
        chk("uart_lag1", 32'(pads.uart_sin_sync), 32'h1);
        cyc(4'h0, 1'b0);
        chk("uart_lag2", 32'(pads.uart_sin_sync), 32'h0);
        repeat (4) cyc(4'h0, 1'b1);
        clear_stats();
        cyc(4'h0, 1'b0);
        repeat (4) cyc(4'h0, 1'b1);
        chk("uart_glitch", 32'(uart_low_cnt), 32'd1);

        // Reset while button 0 is mid-check: no pulse afterwards.
        apply_reset(4'h0, 1'b1, 2);
        repeat (9) cyc(4'h1, 1'b1);
        apply_reset(4'h0, 1'b1, 2);
        clear_stats();
        repeat (20) cyc(4'h0, 1'b1);
        chk("midreset_press_n", 32'(press_cnt[0]), 32'd0);

        // Long hold on button 0: one long pulse with the feature, none without.
        clear_stats();
        repeat (90) cyc(4'h1, 1'b1);
        chk("long_n", 32'(long_cnt[0]), 32'(LONG_EN));
        chk("long_press_n", 32'(press_cnt[0]), 32'd1);

        // Random slow-changing buttons and noisy uart.
        apply_reset(4'h0, 1'b1, 2);
        rb = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N_BTN; i++)
                if ($urandom_range(0, 15) == 0) rb[i] = ~rb[i];
            cyc(rb, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
